io_port_bridge: RTL

//   Host-side peer of the processor's 16-bit I/O ports. Buffers host words in an input FIFO
//   and presents its head on the processor inputPort; the processor pops it on an IN instruction.

---
 rtl/io_port_bridge_if.sv | 35 +++
 rtl/io_port_bridge.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/io_port_bridge_if.sv
// io_port_bridge_if
//   Bundles the data/handshake signals between the host, the processor I/O
//   ports and the io_port_bridge.
//   slave  : the bridge side (accepts host/cpu requests, drives heads/ready)
//   master : the host/processor side
// Signals
//   host_in_data/valid/ready : host -> input FIFO push handshake
//   cpu_in_port/empty/rd     : input FIFO head to processor inputPort, IN pop
//   cpu_out_port/wr          : processor outputPort and OUT write strobe
//   host_out_data/valid/ready: output FIFO head -> host drain handshake
interface io_port_bridge_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] host_in_data;
  logic              host_in_valid;
  logic              host_in_ready;
  logic [DATA_W-1:0] cpu_in_port;
  logic              cpu_in_empty;
  logic              cpu_in_rd;
  logic [DATA_W-1:0] cpu_out_port;
  logic              cpu_out_wr;
  logic [DATA_W-1:0] host_out_data;
  logic              host_out_valid;
  logic              host_out_ready;

  modport slave (
    input  host_in_data, host_in_valid, cpu_in_rd, cpu_out_port, cpu_out_wr, host_out_ready,
    output host_in_ready, cpu_in_port, cpu_in_empty, host_out_data, host_out_valid
  );

  modport master (
    output host_in_data, host_in_valid, cpu_in_rd, cpu_out_port, cpu_out_wr, host_out_ready,
    input  host_in_ready, cpu_in_port, cpu_in_empty, host_out_data, host_out_valid
  );
endinterface

// File: rtl/io_port_bridge.sv
// io_port_bridge
//   Host-side peer of the processor's I/O ports. An input FIFO buffers host
//   words and presents its head (first-word fall-through) on cpu_in_port; the
//   processor pops it with cpu_in_rd. Processor OUT writes are captured into
//   an output FIFO that drains to the host over valid/ready.
// Ports
//   clk          : single clock, rising edge
//   reset        : asynchronous, active-low
//   bus          : io_port_bridge_if.slave (host/cpu data and handshakes)
//   err_clr      : synchronous clear of the sticky error flags
//   in_underflow : sticky, cpu_in_rd seen while the input FIFO was empty
//   out_overflow : sticky, an OUT write was dropped (full, no same-cycle drain)
// Optional feature (macro IO_STATS_EN)
//   in_words / out_words : 16-bit wrapping counts of accepted input pops and
//   accepted output pushes; not affected by err_clr.
module io_port_bridge #(
  parameter int DATA_W    = 16,
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  io_port_bridge_if.slave   bus,
  input  logic              err_clr,
  output logic              in_underflow,
  output logic              out_overflow
`ifdef IO_STATS_EN
  ,
  output logic [15:0]       in_words,
  output logic [15:0]       out_words
`endif
);

  localparam int IN_AW  = $clog2(IN_DEPTH);
  localparam int OUT_AW = $clog2(OUT_DEPTH);
  localparam logic [IN_AW:0]  IN_FULL_C  = (IN_AW+1)'(IN_DEPTH);
  localparam logic [OUT_AW:0] OUT_FULL_C = (OUT_AW+1)'(OUT_DEPTH);

  logic [DATA_W-1:0] in_mem_r  [IN_DEPTH];
  logic [DATA_W-1:0] out_mem_r [OUT_DEPTH];
  logic [IN_AW-1:0]  in_wr_ptr_r, in_rd_ptr_r;
  logic [IN_AW:0]    in_count_r;
  logic [OUT_AW-1:0] out_wr_ptr_r, out_rd_ptr_r;
  logic [OUT_AW:0]   out_count_r;
  logic              in_underflow_r, out_overflow_r;

  logic in_full_s, in_empty_s, in_push_s, in_pop_s, in_uf_set_s;
  logic out_full_s, out_empty_s, out_push_s, out_pop_s, out_of_set_s;

  // Status and handshake decode; outputs depend only on registered state
  assign in_full_s    = (in_count_r == IN_FULL_C);
  assign in_empty_s   = (in_count_r == {(IN_AW+1){1'b0}});
  assign in_push_s    = bus.host_in_valid & ~in_full_s;
  assign in_pop_s     = bus.cpu_in_rd & ~in_empty_s;
  assign in_uf_set_s  = bus.cpu_in_rd & in_empty_s;

  assign out_full_s   = (out_count_r == OUT_FULL_C);
  assign out_empty_s  = (out_count_r == {(OUT_AW+1){1'b0}});
  assign out_pop_s    = ~out_empty_s & bus.host_out_ready;
  // A write into a full FIFO still fits when the host frees a slot this cycle
  assign out_push_s   = bus.cpu_out_wr & (~out_full_s | out_pop_s);
  assign out_of_set_s = bus.cpu_out_wr & out_full_s & ~out_pop_s;

  assign bus.host_in_ready  = ~in_full_s;
  assign bus.cpu_in_empty   = in_empty_s;
  assign bus.cpu_in_port    = in_empty_s ? {DATA_W{1'b0}} : in_mem_r[in_rd_ptr_r];
  assign bus.host_out_valid = ~out_empty_s;
  assign bus.host_out_data  = out_empty_s ? {DATA_W{1'b0}} : out_mem_r[out_rd_ptr_r];
  assign in_underflow       = in_underflow_r;
  assign out_overflow       = out_overflow_r;

  // FIFO storage writes; contents are deliberately left untouched by reset
  always_ff @(posedge clk) begin
    if (in_push_s) in_mem_r[in_wr_ptr_r] <= bus.host_in_data;
    if (out_push_s) out_mem_r[out_wr_ptr_r] <= bus.cpu_out_port;
  end

  // Input FIFO pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_wr_ptr_r <= {IN_AW{1'b0}};
      in_rd_ptr_r <= {IN_AW{1'b0}};
      in_count_r  <= {(IN_AW+1){1'b0}};
    end else begin
      if (in_push_s) in_wr_ptr_r <= in_wr_ptr_r + IN_AW'(1'b1);
      if (in_pop_s)  in_rd_ptr_r <= in_rd_ptr_r + IN_AW'(1'b1);
      case ({in_push_s, in_pop_s})
        2'b10:   in_count_r <= in_count_r + (IN_AW+1)'(1'b1);
        2'b01:   in_count_r <= in_count_r - (IN_AW+1)'(1'b1);
        default: in_count_r <= in_count_r;
      endcase
    end
  end

  // Output FIFO pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_wr_ptr_r <= {OUT_AW{1'b0}};
      out_rd_ptr_r <= {OUT_AW{1'b0}};
      out_count_r  <= {(OUT_AW+1){1'b0}};
    end else begin
      if (out_push_s) out_wr_ptr_r <= out_wr_ptr_r + OUT_AW'(1'b1);
      if (out_pop_s)  out_rd_ptr_r <= out_rd_ptr_r + OUT_AW'(1'b1);
      case ({out_push_s, out_pop_s})
        2'b10:   out_count_r <= out_count_r + (OUT_AW+1)'(1'b1);
        2'b01:   out_count_r <= out_count_r - (OUT_AW+1)'(1'b1);
        default: out_count_r <= out_count_r;
      endcase
    end
  end

  // Sticky error flags; a new event wins over a same-cycle err_clr
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_underflow_r <= 1'b0;
      out_overflow_r <= 1'b0;
    end else begin
      if (in_uf_set_s)  in_underflow_r <= 1'b1;
      else if (err_clr) in_underflow_r <= 1'b0;
      if (out_of_set_s) out_overflow_r <= 1'b1;
      else if (err_clr) out_overflow_r <= 1'b0;
    end
  end

`ifdef IO_STATS_EN
  logic [15:0] in_words_r, out_words_r;
  assign in_words  = in_words_r;
  assign out_words = out_words_r;

  // Traffic counters, wrapping at 16 bits and immune to err_clr
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_words_r  <= 16'd0;
      out_words_r <= 16'd0;
    end else begin
      if (in_pop_s)   in_words_r  <= in_words_r + 16'd1;
      if (out_push_s) out_words_r <= out_words_r + 16'd1;
    end
  end
`endif

endmodule
